// File: rtl/bsg_axil_rxs_pkg.sv
// ============================================================================
//  Module   : bsg_axil_rxs_pkg
//  Purpose  : Shared address map, response codes and state encoding for the
//             buffered AXI-Lite rx read slave.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_axil_rxs_pkg;

    // Address map: [slot field | offset field]; each slot owns a 4 KB window.
    localparam int base_addr_width_gp = 12;
    localparam int slot_idx_width_gp  = 4;
    localparam int slot_base_gp       = 1;

    // Offsets inside a FIFO slot window.
    localparam logic [base_addr_width_gp-1:0] ofs_rdr_gp = 12'h000;
    localparam logic [base_addr_width_gp-1:0] ofs_cnt_gp = 12'h004;

    // Width of the per-slot pop counters.
    localparam int cnt_width_gp = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } rd_state_e;

    typedef enum logic [1:0] {
        OFS_RDR = 2'd0,
        OFS_CNT = 2'd1,
        OFS_REG = 2'd2
    } ofs_class_e;

    // Index width that never collapses to zero bits for a single slot.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_axil_rxs_decode.sv
// ============================================================================
//  Module   : bsg_axil_rxs_decode
//  Purpose  : Combinational classifier for a latched read address: FIFO slot
//             hit, ROM hit or miss, plus the slot index and offset class.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_axil_rxs_decode
    import bsg_axil_rxs_pkg::*;
#(
    parameter int num_fifos_p  = 1,
    parameter int addr_width_p = 32,
    localparam int c_lg_fifos  = safe_clog2(num_fifos_p)
) (
    input  logic [addr_width_p-1:0] i_addr,
    output logic                    o_fifo_hit,
    output logic                    o_rom_hit,
    output logic                    o_miss,
    output logic [c_lg_fifos-1:0]   o_slot,
    output ofs_class_e              o_ofs_class
);

    localparam int c_used_bits = base_addr_width_gp + slot_idx_width_gp;

    logic [slot_idx_width_gp-1:0]  w_field;
    logic [31:0]                   w_field32;
    logic [31:0]                   w_rel;
    logic [base_addr_width_gp-1:0] w_ofs;

    assign w_field   = i_addr[base_addr_width_gp +: slot_idx_width_gp];
    assign w_field32 = 32'(w_field);
    assign w_rel     = w_field32 - 32'(slot_base_gp);
    assign w_ofs     = i_addr[0 +: base_addr_width_gp];

    // Relative slot must be in [0, num_fifos_p); the guard on the low side
    // keeps the unsigned subtraction from wrapping into a false hit.
    assign o_fifo_hit = (w_field32 >= 32'(slot_base_gp)) && (w_rel < 32'(num_fifos_p));
    assign o_rom_hit  = (w_field32 == 32'(slot_base_gp + num_fifos_p));
    assign o_miss     = !o_fifo_hit && !o_rom_hit;

    // Offset classification within a FIFO slot window.
    always_comb begin
        o_ofs_class = OFS_REG;
        if (w_ofs == ofs_rdr_gp) begin
            o_ofs_class = OFS_RDR;
        end else if (w_ofs == ofs_cnt_gp) begin
            o_ofs_class = OFS_CNT;
        end
    end

    generate
        if (num_fifos_p > 1) begin : g_multi
            logic [num_fifos_p-1:0] w_hot;

            // One-hot slot select, qualified by a FIFO hit.
            always_comb begin
                for (int i = 0; i < num_fifos_p; i++) begin
                    w_hot[i] = o_fifo_hit && (w_rel == 32'(i));
                end
            end

            // One-hot to binary encode of the selected slot.
            always_comb begin
                o_slot = '0;
                for (int j = 0; j < num_fifos_p; j++) begin
                    if (w_hot[j]) begin
                        o_slot = o_slot | c_lg_fifos'(j);
                    end
                end
            end
        end else begin : g_single
            assign o_slot = '0;
        end

        if (addr_width_p > c_used_bits) begin : g_upper
            // Bits above the slot field do not take part in decode.
            logic w_unused_upper;
            assign w_unused_upper = ^i_addr[addr_width_p-1:c_used_bits];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bsg_axil_rxs_buffered.sv
// ============================================================================
//  Module   : bsg_axil_rxs_buffered
//  Purpose  : AXI-Lite read slave serving rx FIFO pops, per-slot pop counters,
//             per-slot status words and a monitor/ROM word, with the FIFO pop
//             decoupled from the R handshake by a registered response buffer.
//  Options  : BSG_AXIL_RXS_READ_TIMEOUT_EN - empty-FIFO RDR reads wait up to
//             timeout_p cycles for data instead of failing immediately.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_axil_rxs_buffered
    import bsg_axil_rxs_pkg::*;
#(
    parameter int num_fifos_p  = 1,
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32,
    parameter int timeout_p    = 256
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [addr_width_p-1:0]                araddr_i,
    input  logic                                   arvalid_i,
    output logic                                   arready_o,
    output logic [data_width_p-1:0]                rdata_o,
    output logic [1:0]                             rresp_o,
    output logic                                   rvalid_o,
    input  logic                                   rready_i,
    input  logic [num_fifos_p-1:0][data_width_p-1:0] rxs_i,
    input  logic [num_fifos_p-1:0]                 rxs_v_i,
    output logic [num_fifos_p-1:0]                 rxs_yumi_o,
    output logic [addr_width_p-1:0]                rd_addr_o,
    input  logic [num_fifos_p-1:0][data_width_p-1:0] regs_i,
    input  logic [data_width_p-1:0]                mcl_data_i
);

    localparam int c_lg_fifos = safe_clog2(num_fifos_p);

    rd_state_e                               r_state;
    rd_state_e                               w_state_next;
    logic [addr_width_p-1:0]                 r_rd_addr;
    logic [data_width_p-1:0]                 r_rdata;
    logic [data_width_p-1:0]                 w_rdata_next;
    axil_resp_e                              r_rresp;
    axil_resp_e                              w_rresp_next;
    logic [num_fifos_p-1:0][cnt_width_gp-1:0] r_cnt;

    logic                    w_pop;
    logic                    w_pop_issue;
    logic                    w_fifo_hit;
    logic                    w_rom_hit;
    logic                    w_miss;
    logic [c_lg_fifos-1:0]   w_slot;
    ofs_class_e              w_ofs_class;
    logic                    w_head_v;
    logic [data_width_p-1:0] w_head;
    logic [data_width_p-1:0] w_cnt_word;

    bsg_axil_rxs_decode #(
        .num_fifos_p  (num_fifos_p),
        .addr_width_p (addr_width_p)
    ) u_decode (
        .i_addr      (r_rd_addr),
        .o_fifo_hit  (w_fifo_hit),
        .o_rom_hit   (w_rom_hit),
        .o_miss      (w_miss),
        .o_slot      (w_slot),
        .o_ofs_class (w_ofs_class)
    );

    assign w_head_v = rxs_v_i[w_slot];
    assign w_head   = rxs_i[w_slot];

    // Zero-extend the selected pop counter to the bus width.
    always_comb begin
        w_cnt_word                   = '0;
        w_cnt_word[cnt_width_gp-1:0] = r_cnt[w_slot];
    end

`ifdef BSG_AXIL_RXS_READ_TIMEOUT_EN
    localparam int c_tw = $clog2(timeout_p) + 1;

    logic [c_tw-1:0] r_wait_cnt;
    logic            w_timeout;

    assign w_timeout = (r_wait_cnt == c_tw'(timeout_p - 1));

    // Wait-cycle counter: cleared on the way into WAIT, counts while waiting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wait_cnt <= '0;
        end else if (r_state == DECODE) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_tw'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (timeout_p > 0);
`endif

    // Next-state, response buffer load and pop request.
    always_comb begin
        w_state_next = r_state;
        w_rdata_next = r_rdata;
        w_rresp_next = r_rresp;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (arvalid_i) begin
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                w_state_next = RESP;
                w_rresp_next = OKAY;
                if (w_miss) begin
                    w_rdata_next = '0;
                    w_rresp_next = DECERR;
                end else if (w_rom_hit) begin
                    w_rdata_next = mcl_data_i;
                end else begin
                    case (w_ofs_class)
                        OFS_CNT: w_rdata_next = w_cnt_word;
                        OFS_RDR: begin
                            if (w_head_v) begin
                                w_rdata_next = w_head;
                                w_pop        = 1'b1;
                            end else begin
`ifdef BSG_AXIL_RXS_READ_TIMEOUT_EN
                                w_state_next = WAIT;
`else
                                w_rdata_next = '0;
                                w_rresp_next = SLVERR;
`endif
                            end
                        end
                        default: w_rdata_next = regs_i[w_slot];
                    endcase
                end
            end
`ifdef BSG_AXIL_RXS_READ_TIMEOUT_EN
            WAIT: begin
                if (w_head_v) begin
                    w_rdata_next = w_head;
                    w_rresp_next = OKAY;
                    w_pop        = 1'b1;
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_rdata_next = '0;
                    w_rresp_next = SLVERR;
                    w_state_next = RESP;
                end
            end
`endif
            RESP: begin
                if (rready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A pop is never issued in a reset cycle.
    assign w_pop_issue = w_pop && !reset_i;

    // Pop strobe toward the selected FIFO only.
    always_comb begin
        for (int i = 0; i < num_fifos_p; i++) begin
            rxs_yumi_o[i] = w_pop_issue && (w_slot == c_lg_fifos'(i));
        end
    end

    assign arready_o = (r_state == IDLE);
    assign rvalid_o  = (r_state == RESP);
    assign rdata_o   = r_rdata;
    assign rresp_o   = r_rresp;
    assign rd_addr_o = w_pop_issue ? '0 : r_rd_addr;

    // State, latched address and registered response buffer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_rd_addr <= '0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
        end else begin
            r_state <= w_state_next;
            r_rdata <= w_rdata_next;
            r_rresp <= w_rresp_next;
            if ((r_state == IDLE) && arvalid_i) begin
                r_rd_addr <= araddr_i;
            end
        end
    end

    // Per-slot pop counters, wrapping naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt[w_slot] <= r_cnt[w_slot] + cnt_width_gp'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bsg_axil_rxs_buffered.sv
// ============================================================================
//  Module   : tb_bsg_axil_rxs_buffered
//  Purpose  : Scoreboard bench for bsg_axil_rxs_buffered (two slots).
//  Options  : BSG_AXIL_RXS_READ_TIMEOUT_EN selects the waiting empty-read path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_axil_rxs_buffered;
    import bsg_axil_rxs_pkg::*;

    localparam int NF = 2;
    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic                 clk;
    logic                 reset_i;
    logic [31:0]          araddr_i;
    logic                 arvalid_i;
    logic                 arready_o;
    logic [31:0]          rdata_o;
    logic [1:0]           rresp_o;
    logic                 rvalid_o;
    logic                 rready_i;
    logic [NF-1:0][31:0]  rxs_i;
    logic [NF-1:0]        rxs_v_i;
    logic [NF-1:0]        rxs_yumi_o;
    logic [31:0]          rd_addr_o;
    logic [NF-1:0][31:0]  regs_i;
    logic [31:0]          mcl_data_i;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          yumi_cnt[NF];
    int          pops_m[NF];
    logic [31:0] cnt_m[NF];

    bsg_axil_rxs_buffered #(
        .num_fifos_p  (NF),
        .data_width_p (32),
        .addr_width_p (32),
        .timeout_p    (TO)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .araddr_i   (araddr_i),
        .arvalid_i  (arvalid_i),
        .arready_o  (arready_o),
        .rdata_o    (rdata_o),
        .rresp_o    (rresp_o),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .rxs_i      (rxs_i),
        .rxs_v_i    (rxs_v_i),
        .rxs_yumi_o (rxs_yumi_o),
        .rd_addr_o  (rd_addr_o),
        .regs_i     (regs_i),
        .mcl_data_i (mcl_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External status words: a function of slot index and rd_addr_o.
    always_comb begin
        for (int i = 0; i < NF; i++) begin
            regs_i[i] = 32'h5000_0000 | (32'(i) << 16) | {16'h0, rd_addr_o[15:0]};
        end
    end

    function automatic logic [31:0] mk_addr(input int slot_field, input logic [11:0] ofs);
        return (32'(slot_field) << base_addr_width_gp) | {20'h0, ofs};
    endfunction

    function automatic logic [31:0] exp_reg(input int idx, input logic [31:0] addr);
        return 32'h5000_0000 | (32'(idx) << 16) | {16'h0, addr[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pop monitor, sampled just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rxs_yumi_o != '0) begin
            check_eq("yumi_onehot", 64'($onehot(rxs_yumi_o)), 64'd1);
            check_eq("rdaddr_on_pop", 64'(rd_addr_o), 64'd0);
            for (int i = 0; i < NF; i++) begin
                if (rxs_yumi_o[i]) yumi_cnt[i]++;
            end
        end
    end

    // One read transaction; called at a negedge with the DUT idle.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int exp_lat, input int stall,
                           input int raise_at, input int raise_slot,
                           input logic [31:0] raise_data);
        int          lat;
        exp_t        e;
        logic [31:0] held;
        sb_q.push_back('{data: exp_d, resp: exp_r});
        araddr_i  = addr;
        arvalid_i = 1'b1;
        check_eq({tag, "_arready"}, 64'(arready_o), 64'd1);
        @(negedge clk);
        arvalid_i = 1'b0;
        araddr_i  = '0;
        lat = 1;
        while (!rvalid_o && lat < 1000) begin
            if (lat == raise_at) begin
                rxs_i[raise_slot]   = raise_data;
                rxs_v_i[raise_slot] = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (!rvalid_o) begin
            void'(sb_q.pop_front());
            return;
        end
        held = rdata_o;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_v"}, 64'(rvalid_o), 64'd1);
            check_eq({tag, "_hold_d"}, 64'(rdata_o), 64'(held));
        end
        rready_i = 1'b1;
        e = sb_q.pop_front();
        check_eq({tag, "_data"}, 64'(rdata_o), 64'(e.data));
        check_eq({tag, "_resp"}, 64'(rresp_o), 64'(e.resp));
        @(negedge clk);
        rready_i = 1'b0;
        check_eq({tag, "_back_idle"}, 64'(arready_o), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_i    = 1'b1;
        araddr_i   = '0;
        arvalid_i  = 1'b0;
        rready_i   = 1'b0;
        rxs_i      = '0;
        rxs_v_i    = '0;
        mcl_data_i = 32'h1234_5678;
        for (int i = 0; i < NF; i++) begin
            yumi_cnt[i] = 0;
            pops_m[i]   = 0;
            cnt_m[i]    = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_arready", 64'(arready_o), 64'd1);
        check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
        check_eq("rst_rresp", 64'(rresp_o), 64'd0);
        check_eq("rst_rdata", 64'(rdata_o), 64'd0);
        check_eq("rst_yumi", 64'(rxs_yumi_o), 64'd0);
        check_eq("rst_rdaddr", 64'(rd_addr_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // ROM word
        do_read("rom", mk_addr(slot_base_gp + NF, 12'h000), 32'h1234_5678, OKAY, 2, 0, 0, 0, '0);

        // Pop from FIFO 1 under R backpressure
        rxs_i[1] = 32'hA5A5_0001;
        rxs_v_i[1] = 1'b1;
        do_read("pop_bp", mk_addr(slot_base_gp + 1, ofs_rdr_gp), 32'hA5A5_0001, OKAY, 2, 5, 0, 0, '0);
        rxs_v_i[1] = 1'b0;
        pops_m[1]++;
        cnt_m[1] = cnt_m[1] + 32'd1;
        check_eq("pop_bp_yumi1", 64'(yumi_cnt[1]), 64'(pops_m[1]));
        check_eq("pop_bp_yumi0", 64'(yumi_cnt[0]), 64'(pops_m[0]));

        // Counters and status words
        do_read("cnt1", mk_addr(slot_base_gp + 1, ofs_cnt_gp), cnt_m[1], OKAY, 2, 0, 0, 0, '0);
        do_read("cnt0", mk_addr(slot_base_gp, ofs_cnt_gp), cnt_m[0], OKAY, 2, 0, 0, 0, '0);
        do_read("reg0", mk_addr(slot_base_gp, 12'h010),
                exp_reg(0, mk_addr(slot_base_gp, 12'h010)), OKAY, 2, 0, 0, 0, '0);
        do_read("reg1", mk_addr(slot_base_gp + 1, 12'h020),
                exp_reg(1, mk_addr(slot_base_gp + 1, 12'h020)), OKAY, 2, 1, 0, 0, '0);

        // Decode misses with a FIFO ready: no pop may occur
        rxs_i[0] = 32'hDEAD_0000;
        rxs_v_i[0] = 1'b1;
        do_read("miss_hi", mk_addr(slot_base_gp + NF + 1, ofs_rdr_gp), '0, DECERR, 2, 0, 0, 0, '0);
        do_read("miss_lo", mk_addr(0, ofs_rdr_gp), '0, DECERR, 2, 0, 0, 0, '0);
        rxs_v_i[0] = 1'b0;
        check_eq("miss_no_pop", 64'(yumi_cnt[0]), 64'(pops_m[0]));

        // Empty RDR reads
`ifdef BSG_AXIL_RXS_READ_TIMEOUT_EN
        do_read("empty_late", mk_addr(slot_base_gp, ofs_rdr_gp), 32'hC0FF_EE01, OKAY, 11, 0, 10, 0,
                32'hC0FF_EE01);
        rxs_v_i[0] = 1'b0;
        pops_m[0]++;
        cnt_m[0] = cnt_m[0] + 32'd1;
        check_eq("empty_late_pop", 64'(yumi_cnt[0]), 64'(pops_m[0]));
        do_read("empty_to", mk_addr(slot_base_gp + 1, ofs_rdr_gp), '0, SLVERR, 2 + TO, 0, 0, 0, '0);
        check_eq("empty_to_nopop", 64'(yumi_cnt[1]), 64'(pops_m[1]));
`else
        do_read("empty", mk_addr(slot_base_gp, ofs_rdr_gp), '0, SLVERR, 2, 0, 0, 0, '0);
        check_eq("empty_nopop", 64'(yumi_cnt[0]), 64'(pops_m[0]));
`endif
        do_read("cnt0_b", mk_addr(slot_base_gp, ofs_cnt_gp), cnt_m[0], OKAY, 2, 0, 0, 0, '0);

        // Counter wrap from a preloaded all-ones value
        force dut.r_cnt = {cnt_m[1], 32'hFFFF_FFFF};
        @(negedge clk);
        release dut.r_cnt;
        cnt_m[0] = 32'hFFFF_FFFF;
        do_read("cnt_preload", mk_addr(slot_base_gp, ofs_cnt_gp), cnt_m[0], OKAY, 2, 0, 0, 0, '0);
        rxs_i[0] = 32'h0BAD_F00D;
        rxs_v_i[0] = 1'b1;
        do_read("pop_wrap", mk_addr(slot_base_gp, ofs_rdr_gp), 32'h0BAD_F00D, OKAY, 2, 0, 0, 0, '0);
        rxs_v_i[0] = 1'b0;
        pops_m[0]++;
        cnt_m[0] = cnt_m[0] + 32'd1;
        do_read("cnt_wrap", mk_addr(slot_base_gp, ofs_cnt_gp), cnt_m[0], OKAY, 2, 0, 0, 0, '0);
        do_read("cnt1_keep", mk_addr(slot_base_gp + 1, ofs_cnt_gp), cnt_m[1], OKAY, 2, 0, 0, 0, '0);

        // Reset while in DECODE with a pop pending: the pop must be suppressed
        rxs_i[1] = 32'h6666_0001;
        rxs_v_i[1] = 1'b1;
        araddr_i = mk_addr(slot_base_gp + 1, ofs_rdr_gp);
        arvalid_i = 1'b1;
        @(negedge clk);
        arvalid_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        rxs_v_i[1] = 1'b0;
        for (int i = 0; i < NF; i++) cnt_m[i] = '0;
        check_eq("rst_dec_nopop", 64'(yumi_cnt[1]), 64'(pops_m[1]));
        check_eq("rst_dec_arready", 64'(arready_o), 64'd1);
        check_eq("rst_dec_rvalid", 64'(rvalid_o), 64'd0);

        // Reset while a response is pending in RESP
        rxs_i[1] = 32'h7777_0002;
        rxs_v_i[1] = 1'b1;
        araddr_i = mk_addr(slot_base_gp + 1, ofs_rdr_gp);
        arvalid_i = 1'b1;
        @(negedge clk);
        arvalid_i = 1'b0;
        @(negedge clk);
        rxs_v_i[1] = 1'b0;
        pops_m[1]++;
        check_eq("rst_resp_pre_rvalid", 64'(rvalid_o), 64'd1);
        check_eq("rst_resp_pop", 64'(yumi_cnt[1]), 64'(pops_m[1]));
        reset_i = 1'b1;
        @(negedge clk);
        check_eq("rst_resp_rvalid", 64'(rvalid_o), 64'd0);
        check_eq("rst_resp_arready", 64'(arready_o), 64'd1);
        check_eq("rst_resp_rdata", 64'(rdata_o), 64'd0);
        check_eq("rst_resp_rdaddr", 64'(rd_addr_o), 64'd0);
        reset_i = 1'b0;
        for (int i = 0; i < NF; i++) cnt_m[i] = '0;
        @(negedge clk);
        do_read("post_rst_cnt0", mk_addr(slot_base_gp, ofs_cnt_gp), cnt_m[0], OKAY, 2, 0, 0, 0, '0);
        do_read("post_rst_cnt1", mk_addr(slot_base_gp + 1, ofs_cnt_gp), cnt_m[1], OKAY, 2, 0, 0, 0, '0);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bsg_axil_rxs_buffered.md
Name: bsg_axil_rxs_buffered

Overview:
AXI-Lite read slave that serves host reads from num_fifos_p receive FIFOs, per-slot status registers and a monitor/ROM word. It is the parametrised successor of the single-outstanding rx slave:
- Data and address widths are parametrised.
- The FIFO pop is decoupled from the R handshake through a registered response buffer.
- Each slot has a pop counter.
- Reads of an empty FIFO are handled explicitly.

It sits between the AXI-Lite crossbar port and the manycore-link rx FIFOs.

Parameters:
num_fifos_p, 1, number of rx FIFOs / slots (>=1)
data_width_p, 32, AXI-Lite data width (32 or 64)
addr_width_p, 32, AXI-Lite address width
timeout_p, 256, max wait cycles on an empty-FIFO read (used only with the optional feature)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
araddr_i  in  addr_width_p  read address
arvalid_i  in  1  read address valid
arready_o  out  1  read address ready
rdata_o  out  data_width_p  read data
rresp_o  out  2  read response
rvalid_o  out  1  read data valid
rready_i  in  1  read data ready
rxs_i  in  num_fifos_p x data_width_p  FIFO head data
rxs_v_i  in  num_fifos_p  FIFO head valid
rxs_yumi_o  out  num_fifos_p  FIFO pop (one-hot or zero)
rd_addr_o  out  addr_width_p  latched address for external register read
regs_i  in  num_fifos_p x data_width_p  per-slot status word, combinational on rd_addr_o
mcl_data_i  in  data_width_p  monitor/ROM word, combinational on rd_addr_o

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - arready_o=1, rvalid_o=0, rresp_o=0, rdata_o=0, rxs_yumi_o=0.
  - rd_addr_o=0, all pop counters=0.
- Address decode fields:
  - slot = addr[base_addr_width_gp +: slot_idx_width_gp]
  - ofs = addr[0 +: base_addr_width_gp]
- Address classification:
  - FIFO hit: slot-slot_base_gp is in [0, num_fifos_p).
  - ROM hit: slot == slot_base_gp+num_fifos_p.
  - Anything else is a miss.
- States: IDLE, DECODE, WAIT, RESP.
- IDLE:
  - arready_o=1.
  - On arvalid_i, latch araddr_i into rd_addr_r and go to DECODE.
- DECODE (one cycle):
  - Miss: rdata_r=0, rresp=DECERR (2'b11), go to RESP.
  - ROM hit: rdata_r=mcl_data_i, OKAY, go to RESP.
  - FIFO hit, ofs==ofs_cnt_gp: rdata_r=cnt[slot], zero-extended to data_width_p, OKAY, go to RESP.
  - FIFO hit, ofs==ofs_rdr_gp, rxs_v_i[slot]=1: rdata_r=rxs_i[slot], rxs_yumi_o[slot]=1 this cycle, cnt[slot]+=1, OKAY, go to RESP.
  - FIFO hit, ofs==ofs_rdr_gp, rxs_v_i[slot]=0: handling depends on the optional feature.
  - FIFO hit, other ofs: rdata_r=regs_i[slot], OKAY, go to RESP.
- RESP:
  - rvalid_o=1; rdata_o and rresp_o are held stable from registers.
  - On rready_i, go to IDLE.
  - arready_o=0 in DECODE, WAIT and RESP, so at most one read is outstanding.
- Latency: AR handshake in cycle N gives rvalid_o in cycle N+2, plus any WAIT cycles.
- Pop semantics:
  - The FIFO is popped exactly once per successful RDR read.
  - The pop happens before the R handshake.
  - R backpressure therefore never causes a double pop or a lost word.
- Pop counters: 32-bit, wrap 0xFFFF_FFFF -> 0.
- rd_addr_o: equals rd_addr_r. It is forced to 0 while a pop is issued.
- Reset mid-transaction:
  - Return to IDLE and drop any pending response.
  - No pop is issued in the reset cycle.
  - Counters clear.

Optional Feature:
Macro BSG_AXIL_RXS_READ_TIMEOUT_EN.
- Defined (empty-FIFO read in DECODE enters WAIT):
  - Timeout counter loads 0.
  - Each WAIT cycle with rxs_v_i[slot]=1: pop, capture data, OKAY, go to RESP.
  - When the counter reaches timeout_p-1 with the FIFO still empty: rdata_r=0, SLVERR (2'b10), no pop, go to RESP.
- Undefined: an empty RDR read goes directly from DECODE to RESP with rdata=0 and SLVERR. The WAIT state and timeout logic are not built.

Decomposition:
- Package bsg_axil_rxs_pkg holds:
  - base_addr_width_gp, slot_idx_width_gp, slot_base_gp
  - ofs_rdr_gp, ofs_cnt_gp
  - the resp encodings OKAY/SLVERR/DECERR as an enum
  - the rd_state_e typedef
- Sub-module bsg_axil_rxs_decode: combinational address classifier returning fifo_hit, rom_hit, miss, slot index (bsg_encode_one_hot for num_fifos_p>1) and ofs class.

Test Plan:
- ROM read: araddr = ROM slot, mcl_data_i=0x1234_5678 -> rdata 0x1234_5678, OKAY, rvalid 2 cycles after AR handshake.
- Pop with backpressure: FIFO 1 holds 0xA5A5_0001, RDR read, rready_i low for 5 cycles -> exactly one rxs_yumi_o[1] pulse, data held stable, OKAY, cnt[1]=1.
- Decode miss: address with slot = slot_base_gp+num_fifos_p+1 -> DECERR, rdata 0, no pop.
- Empty RDR read:
  - Feature undefined: SLVERR immediately.
  - Feature defined, rxs_v_i raised after 10 cycles: OKAY with the data.
  - Feature defined, FIFO never valid: SLVERR after timeout_p cycles.
- Counter wrap: 2^32 pops forced via a preloaded counter at 0xFFFF_FFFF, one more pop -> CNT read returns 0.
- Reset mid-RESP: reset_i asserted while rvalid_o=1 -> next cycle rvalid_o=0, arready_o=1, counters 0.
